// File: rtl/epu_exp_pkg.sv
// Shared types and constants for the EPU exponent path. fp32_exp_lut and every
// arbiter in front of it agree on the LUT latency and the tag format here.
package epu_exp_pkg;

  // Index width for N requesters; a single requester still needs a 1-bit id.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pipeline depth of fp32_exp_lut, in_valid -> out_valid.
  localparam int EXP_LUT_LAT = 1;

  // Requester count that the shared tag format is sized for.
  localparam int EXP_N_REQ = 4;
  localparam int EXP_TAG_ID_W = id_w(EXP_N_REQ);

  // A tag travels alongside each LUT op so its result can be steered back.
  typedef struct packed {
    logic                    v;
    logic [EXP_TAG_ID_W-1:0] id;
  } exp_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first eligible index at or after
// ptr, searching upward with wrap-around, as one-hot, binary index and any-flag.
module rr_pick
  import epu_exp_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gidx,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Walk N positions starting at ptr and keep the first eligible one.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!any && eligible[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/exp_lut_rr_arbiter.sv
// Shares one fp32_exp_lut among N_REQ requesters. Round-robin grant, one op per
// cycle, one outstanding op per requester, results steered back by tag into
// per-requester holding slots that stay put until the requester takes them.
module exp_lut_rr_arbiter
  import epu_exp_pkg::*;
#(
  parameter int N_REQ  = EXP_N_REQ,
  parameter int DATA_W = 32,
  parameter int LAT    = EXP_LUT_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_x,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*DATA_W-1:0]   rsp_y,
  output logic                      lut_in_valid,
  output logic [DATA_W-1:0]         lut_x,
  input  logic                      lut_out_valid,
  input  logic [DATA_W-1:0]         lut_y,
  output logic                      busy,
  output logic                      err_tag
);

  localparam int ID_W = id_w(N_REQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              lut_in_valid_q, lut_in_valid_d;
  logic [DATA_W-1:0] lut_x_q, lut_x_d;
  logic [ID_W-1:0]   issue_id_q, issue_id_d;
  exp_tag_t          tag_pipe_q [LAT];
  exp_tag_t          tag_pipe_d [LAT];
  logic [N_REQ-1:0]  outstanding_q, outstanding_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] slot_q [N_REQ];
  logic [DATA_W-1:0] slot_d [N_REQ];
  logic              err_tag_q, err_tag_d;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gidx;
  logic              any_grant;
  exp_tag_t          pop;
  logic [ID_W-1:0]   pop_id;

  // A requester with a result still held (or in flight) cannot be granted again.
  assign eligible = req_valid & ~outstanding_q;

  rr_pick #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .gidx     (gidx),
    .any      (any_grant)
  );

  assign pop    = tag_pipe_q[LAT-1];
  assign pop_id = ID_W'(pop.id);

  // Next-state for pointer, issue register, tag pipe, outstanding set and slots.
  always_comb begin
    ptr_d          = ptr_q;
    lut_in_valid_d = any_grant;
    lut_x_d        = lut_x_q;
    issue_id_d     = issue_id_q;
    if (any_grant) begin
      ptr_d      = (gidx == ID_W'(N_REQ - 1)) ? '0 : ID_W'(gidx + 1'b1);
      issue_id_d = gidx;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) lut_x_d = req_x[i*DATA_W +: DATA_W];
    end

    tag_pipe_d[0] = '{v: lut_in_valid_q, id: EXP_TAG_ID_W'(issue_id_q)};
    for (int k = 1; k < LAT; k++) begin
      tag_pipe_d[k] = tag_pipe_q[k-1];
    end

    outstanding_d = (outstanding_q | grant) & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d   = rsp_valid_q & ~rsp_ready;
    slot_d        = slot_q;
    err_tag_d     = err_tag_q;

    if (pop.v && lut_out_valid) begin
      rsp_valid_d[pop_id] = 1'b1;
      slot_d[pop_id]      = lut_y;
    end else if (pop.v) begin
      outstanding_d[pop_id] = 1'b0;
      err_tag_d             = 1'b1;
    end else if (lut_out_valid) begin
      err_tag_d = 1'b1;
    end
  end

  // State registers; reset drops anything in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      lut_in_valid_q <= 1'b0;
      lut_x_q        <= '0;
      issue_id_q     <= '0;
      outstanding_q  <= '0;
      rsp_valid_q    <= '0;
      err_tag_q      <= 1'b0;
      for (int k = 0; k < LAT; k++) tag_pipe_q[k] <= '0;
      for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
    end else begin
      ptr_q          <= ptr_d;
      lut_in_valid_q <= lut_in_valid_d;
      lut_x_q        <= lut_x_d;
      issue_id_q     <= issue_id_d;
      outstanding_q  <= outstanding_d;
      rsp_valid_q    <= rsp_valid_d;
      err_tag_q      <= err_tag_d;
      tag_pipe_q     <= tag_pipe_d;
      slot_q         <= slot_d;
    end
  end

  // Flatten the holding slots onto the response bus.
  always_comb begin
    rsp_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_y[i*DATA_W +: DATA_W] = slot_q[i];
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign lut_in_valid = lut_in_valid_q;
  assign lut_x        = lut_x_q;
  assign busy         = |outstanding_q;
  assign err_tag      = err_tag_q;

endmodule

// File: tb/tb_exp_lut_rr_arbiter.sv
// Bench for exp_lut_rr_arbiter. A one-cycle stand-in for fp32_exp_lut sits behind
// the arbiter (with hooks to force or drop out_valid), and a queue-based model of
// the arbitration rules predicts every output on every cycle.
module tb_exp_lut_rr_arbiter;
  import epu_exp_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = EXP_LUT_LAT;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_x, rsp_y;
  logic           lut_in_valid, lut_out_valid, busy, err_tag;
  logic [W-1:0]   lut_x, lut_y;
  logic           stub_valid, force_ov, drop_ov;
  logic [W-1:0]   stub_y;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           id;
    int           pop_cyc;
    logic [W-1:0] x;
  } op_t;

  int           m_ptr, m_cyc;
  bit           m_out [N];
  bit           m_rv  [N];
  logic [W-1:0] m_ry  [N];
  bit           m_liv;
  logic [W-1:0] m_lx;
  bit           m_err;
  op_t          inflight [$];

  exp_lut_rr_arbiter dut (
    .clk           (clock),
    .rst           (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_y         (rsp_y),
    .lut_in_valid  (lut_in_valid),
    .lut_x         (lut_x),
    .lut_out_valid (lut_out_valid),
    .lut_y         (lut_y),
    .busy          (busy),
    .err_tag       (err_tag)
  );

  always #5 clock = ~clock;

  // Stand-in LUT transfer function; maps 0 to 1.0 in Q16.16 like exp().
  function automatic logic [W-1:0] exp_stub(input logic [W-1:0] x);
    return (x * 32'h9E37_79B1) ^ 32'h0001_0000;
  endfunction

  // Round-robin rule: first requester at or after ptr that is valid and idle.
  function automatic int pick(input int ptr, input logic [N-1:0] rv, input bit out_s [N]);
    for (int k = 0; k < N; k++) begin
      if (rv[(ptr + k) % N] && !out_s[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One-cycle LUT stand-in, with fault hooks applied on its output.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      stub_valid <= 1'b0;
      stub_y     <= '0;
    end else begin
      stub_valid <= lut_in_valid;
      stub_y     <= exp_stub(lut_x);
    end
  end
  assign lut_out_valid = (stub_valid & ~drop_ov) | force_ov;
  assign lut_y         = stub_y;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] r);
    req_valid = v;
    rsp_ready = r;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    force_ov  = 1'b0;
    drop_ov   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Model compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clock) begin
    int           g;
    int           hit;
    logic [N-1:0] exp_ready;
    logic [N-1:0] rv_vec;
    bit           any_out;
    if (reset) begin
      m_ptr = 0;
      m_cyc = 0;
      m_liv = 1'b0;
      m_lx  = '0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_out[i] = 1'b0;
        m_rv[i]  = 1'b0;
        m_ry[i]  = '0;
      end
      inflight.delete();
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_lut_in_valid", 32'(lut_in_valid), 32'h0);
      checkOutput("rst_lut_x", lut_x, 32'h0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rst_rsp_y_lo", rsp_y[31:0], 32'h0);
      checkOutput("rst_rsp_y_hi", rsp_y[127:96], 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_err_tag", 32'(err_tag), 32'h0);
    end else begin
      g         = pick(m_ptr, req_valid, m_out);
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      rv_vec    = '0;
      any_out   = 1'b0;
      for (int i = 0; i < N; i++) begin
        rv_vec[i] = m_rv[i];
        any_out   = any_out | m_out[i];
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("lut_in_valid", 32'(lut_in_valid), 32'(m_liv));
      checkOutput("lut_x", lut_x, m_lx);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(rv_vec));
      for (int i = 0; i < N; i++) begin
        if (m_rv[i]) checkOutput($sformatf("rsp_y%0d", i), rsp_y[i*W +: W], m_ry[i]);
      end
      checkOutput("busy", 32'(busy), 32'(any_out));
      checkOutput("err_tag", 32'(err_tag), 32'(m_err));

      for (int i = 0; i < N; i++) begin
        if (m_rv[i] && rsp_ready[i]) begin
          m_rv[i]  = 1'b0;
          m_out[i] = 1'b0;
        end
      end
      hit = -1;
      foreach (inflight[k]) if (inflight[k].pop_cyc == m_cyc) hit = k;
      if (hit >= 0) begin
        if (lut_out_valid) begin
          m_rv[inflight[hit].id] = 1'b1;
          m_ry[inflight[hit].id] = exp_stub(inflight[hit].x);
        end else begin
          m_err                   = 1'b1;
          m_out[inflight[hit].id] = 1'b0;
        end
        inflight.delete(hit);
      end else if (lut_out_valid) begin
        m_err = 1'b1;
      end
      if (g >= 0) begin
        m_out[g] = 1'b1;
        m_ptr    = (g + 1) % N;
        m_liv    = 1'b1;
        m_lx     = req_x[g*W +: W];
        inflight.push_back('{id: g, pop_cyc: m_cyc + 1 + LAT, x: m_lx});
      end else begin
        m_liv = 1'b0;
      end
      m_cyc++;
    end
  end

  // Directed scenarios first, then a randomized soak.
  initial begin
    int last0;
    int last2;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_x     = '0;
    force_ov  = 1'b0;
    drop_ov   = 1'b0;
    doReset();

    // Single op: exp(0) comes back as 1.0 three cycles after the grant.
    req_x[31:0] = 32'h0;
    applyStimulus(4'b0001, 4'b1111);
    #1 checkOutput("t2_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    #1 checkOutput("t2_lut_in_valid", 32'(lut_in_valid), 32'h1);
    checkOutput("t2_lut_x", lut_x, 32'h0);
    tick();
    #1 checkOutput("t2_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    #1 checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t2_rsp_y", rsp_y[31:0], 32'h0001_0000);
    tick();

    // All four valid: grants 0,1,2,3 back to back, then a reset mid-stream.
    doReset();
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 32'h0001_1000 * (i + 1);
    applyStimulus(4'b1111, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 4) checkOutput($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(1 << k));
      if (k >= 1) checkOutput($sformatf("t3_issue%0d", k), 32'(lut_in_valid), 32'h1);
      tick();
    end
    repeat (3) tick();
    doReset();
    applyStimulus(4'b0000, 4'b1111);
    repeat (4) tick();
    applyStimulus(4'b1111, 4'b1111);
    #1 checkOutput("t1_first_after_rst", 32'(req_ready), 32'h1);
    tick();

    // Backpressure on requester 1: its slot holds and it is not re-granted.
    doReset();
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 32'h0003_2000 + 32'(i);
    applyStimulus(4'b1111, 4'b1101);
    repeat (6) tick();
    for (int k = 0; k < 10; k++) begin
      #1 checkOutput("t4_no_regrant1", 32'(req_ready[1]), 32'h0);
      checkOutput("t4_rsp_valid1", 32'(rsp_valid[1]), 32'h1);
      checkOutput("t4_rsp_y1", rsp_y[63:32], exp_stub(32'h0003_2001));
      tick();
    end
    applyStimulus(4'b1111, 4'b1111);
    repeat (6) tick();

    // Fairness with ptr parked at 3: requesters 0 and 2 alternate.
    doReset();
    applyStimulus(4'b0100, 4'b1111);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    repeat (5) tick();
    applyStimulus(4'b0101, 4'b1111);
    #1 checkOutput("t5_first", 32'(req_ready), 32'h1);
    tick();
    #1 checkOutput("t5_second", 32'(req_ready), 32'h4);
    last0 = 0;
    last2 = 1;
    for (int c = 2; c < 20; c++) begin
      tick();
      #1;
      if (req_ready[0]) begin
        checkOutput("t5_wait0", 32'(c - last0 <= N), 32'h1);
        last0 = c;
      end
      if (req_ready[2]) begin
        checkOutput("t5_wait2", 32'(c - last2 <= N), 32'h1);
        last2 = c;
      end
    end
    checkOutput("t5_recent0", 32'(last0 >= 20 - N), 32'h1);

    // Spurious out_valid with nothing in flight.
    doReset();
    applyStimulus(4'b0000, 4'b1111);
    tick();
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    #1 checkOutput("t6_err_set", 32'(err_tag), 32'h1);
    checkOutput("t6_no_rsp", 32'(rsp_valid), 32'h0);
    repeat (3) tick();
    #1 checkOutput("t6_err_sticky", 32'(err_tag), 32'h1);

    // Dropped out_valid: requester freed and granted again.
    doReset();
    req_x[31:0] = 32'h0000_0005;
    drop_ov     = 1'b1;
    applyStimulus(4'b0001, 4'b1111);
    tick();
    tick();
    tick();
    drop_ov = 1'b0;
    #1 checkOutput("t6_drop_err", 32'(err_tag), 32'h1);
    checkOutput("t6_drop_busy", 32'(busy), 32'h0);
    checkOutput("t6_drop_no_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("t6_regrant", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    repeat (4) tick();

    // Randomized soak against the model.
    doReset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_x[i*W +: W] = $urandom;
        rsp_ready[i]    = ($urandom_range(0, 3) != 0);
      end
      req_valid = N'($urandom);
      tick();
    end
    applyStimulus(4'b0000, 4'b1111);
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
